car_lane_scheduler: RTL and testbench

Sequences the car positions that drive the sprite colour generator. It produces the eight `car_x` lane positions, one per car. Positions are updated only during vertical blanking, so a car never tears mid-frame. Each lane has its own frame divider, its own direction and modulo-screen wrap-around. A small lane-walking state machine updates one lane per clock.

---
 rtl/car_lane_scheduler_pkg.sv | 44 ++++
 rtl/car_lane_scheduler_lane_step.sv | 44 ++++
 rtl/car_lane_scheduler.sv | 113 +++++++++++
 tb/tb_car_lane_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_lane_scheduler_pkg.sv
// car_lane_scheduler_pkg
// Constants shared by the car lane scheduler and the sprite colour generator:
// screen geometry, lane count and movement step, the per-lane base periods and
// start positions, and the lane-walking FSM state encoding.
package car_lane_scheduler_pkg;

    localparam int NUM_LANES  = 8;
    localparam int LANE_IDX_W = 3;

    localparam logic [9:0] H_DISPLAY = 10'd640;
    localparam logic [9:0] V_DISPLAY = 10'd480;
    localparam logic [3:0] STEP      = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lane_state_e;

    // Base frame period per lane: {4,3,5,2,4,3,5,2}
    function automatic logic [3:0] lane_period(input logic [2:0] idx);
        logic [3:0] p;
        case (idx)
            3'd0, 3'd4: p = 4'd4;
            3'd1, 3'd5: p = 4'd3;
            3'd2, 3'd6: p = 4'd5;
            default:    p = 4'd2;
        endcase
        return p;
    endfunction

    function automatic logic [9:0] lane_init_x(input logic [2:0] idx);
        return 10'(idx) * 10'd80;
    endfunction

    // max(1, period - level) without going negative in 4 bits
    function automatic logic [3:0] lane_eff(input logic [3:0] period, input logic [2:0] level);
        if ({1'b0, level} >= period) begin
            return 4'd1;
        end
        return period - {1'b0, level};
    endfunction

endpackage

// File: rtl/car_lane_scheduler_lane_step.sv
// car_lane_scheduler_lane_step
// Combinational next-state for one lane: decides whether the lane moves this
// frame and computes the wrapped position.
//   x_i        current position, 0..H_DISPLAY-1
//   div_i      lane frame divider count
//   eff_i      effective period (>= 1)
//   dir_i      1 = move right, 0 = move left
//   x_next_o   position after this update
//   div_next_o divider after this update
module car_lane_scheduler_lane_step
    import car_lane_scheduler_pkg::*;
(
    input  logic [9:0] x_i,
    input  logic [3:0] div_i,
    input  logic [3:0] eff_i,
    input  logic       dir_i,
    output logic [9:0] x_next_o,
    output logic [3:0] div_next_o
);

    logic [10:0] x_ext;
    logic [10:0] right_sum;
    logic        move;

    always_comb begin
        x_ext      = {1'b0, x_i};
        right_sum  = x_ext + 11'(STEP);
        // >= rather than == so a level raise mid-count moves on the next update
        move       = (div_i >= (eff_i - 4'd1));
        x_next_o   = x_i;
        div_next_o = div_i + 4'd1;
        if (move) begin
            div_next_o = '0;
            if (dir_i) begin
                x_next_o = (right_sum >= 11'(H_DISPLAY)) ? 10'(right_sum - 11'(H_DISPLAY))
                                                         : right_sum[9:0];
            end else begin
                x_next_o = (x_i < 10'(STEP)) ? 10'(x_ext + 11'(H_DISPLAY) - 11'(STEP))
                                             : 10'(x_ext - 11'(STEP));
            end
        end
    end

endmodule

// File: rtl/car_lane_scheduler.sv
// car_lane_scheduler
// Updates the eight car lane positions once per frame, during vertical blanking,
// one lane per clock.
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   v_count_i      current VGA line
//   level_i        difficulty 0..7 (higher = faster)
//   pause_i        freezes all motion while high
//   car_x_o        packed lane positions, lane i at [i*10 +: 10]
//   frame_tick_o   one-cycle pulse at each vblank start
//   busy_o         high while lanes are being updated
//   update_done_o  one-cycle pulse after the last lane is written
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for frame start (held here while paused)
// UPDATE  | writing lane lane_idx_q, one lane per clock
// DONE    | sweep finished, pulse update_done_o, back to IDLE
module car_lane_scheduler
    import car_lane_scheduler_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [9:0]                v_count_i,
    input  logic [2:0]                level_i,
    input  logic                      pause_i,
    output logic [10*NUM_LANES-1:0]   car_x_o,
    output logic                      frame_tick_o,
    output logic                      busy_o,
    output logic                      update_done_o
);

    lane_state_e           state_q, state_d;
    logic [LANE_IDX_W-1:0] lane_idx_q, lane_idx_d;
    logic                  vmatch_q;
    logic                  frame_tick_q;
    logic [9:0]            x_q   [NUM_LANES];
    logic [3:0]            div_q [NUM_LANES];

    logic                  frame_start;
    logic                  lane_we;
    logic [3:0]            eff_cur;
    logic [9:0]            x_next;
    logic [3:0]            div_next;

    assign frame_start = (v_count_i == V_DISPLAY) && !vmatch_q;
    assign eff_cur     = lane_eff(lane_period(lane_idx_q), level_i);
    // A pause arriving mid-sweep stalls on the current lane without writing it
    assign lane_we     = (state_q == ST_UPDATE) && !pause_i;

    car_lane_scheduler_lane_step u_lane_step (
        .x_i        (x_q[lane_idx_q]),
        .div_i      (div_q[lane_idx_q]),
        .eff_i      (eff_cur),
        .dir_i      (lane_idx_q[0]),
        .x_next_o   (x_next),
        .div_next_o (div_next)
    );

    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start && !pause_i) begin
                    state_d    = ST_UPDATE;
                    lane_idx_d = '0;
                end
            end
            ST_UPDATE: begin
                if (!pause_i) begin
                    lane_idx_d = lane_idx_q + 1'b1;
                    if (lane_idx_q == LANE_IDX_W'(NUM_LANES - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            lane_idx_q   <= '0;
            vmatch_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                x_q[i]   <= lane_init_x(3'(i));
                div_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            lane_idx_q   <= lane_idx_d;
            vmatch_q     <= (v_count_i == V_DISPLAY);
            frame_tick_q <= frame_start;
            if (lane_we) begin
                x_q[lane_idx_q]   <= x_next;
                div_q[lane_idx_q] <= div_next;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_car_x
        assign car_x_o[g*10 +: 10] = x_q[g];
    end

    assign frame_tick_o  = frame_tick_q;
    assign busy_o        = (state_q == ST_UPDATE);
    assign update_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_car_lane_scheduler.sv
// tb_car_lane_scheduler
// Scoreboard bench: each issued frame pushes its expected lane vector; a monitor
// pops and compares on every update_done pulse and checks sweep latency.
module tb_car_lane_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  v_count = 10'd0;
    logic [2:0]  level = 3'd0;
    logic        pause = 1'b0;
    logic [79:0] car_x;
    logic        frame_tick, busy, update_done;

    always #5 clk = ~clk;

    car_lane_scheduler dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .v_count_i     (v_count),
        .level_i       (level),
        .pause_i       (pause),
        .car_x_o       (car_x),
        .frame_tick_o  (frame_tick),
        .busy_o        (busy),
        .update_done_o (update_done)
    );

    typedef struct {
        string       tag;
        logic [79:0] exp_x;
        logic [79:0] hand_mask;
        logic [79:0] hand_x;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0, tick_cyc = -1000, tick_count = 0, busy_cycles = 0, done_cycles = 0;
    int m_x[8];
    int m_div[8];
    int per[8] = '{4, 3, 5, 2, 4, 3, 5, 2};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] lane_field(input int lane, input int val);
        logic [79:0] v;
        v = '0;
        v[lane*10 +: 10] = 10'(val);
        return v;
    endfunction

    function automatic logic [79:0] init_vec();
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*10 +: 10] = 10'(80 * i);
        return v;
    endfunction

    function automatic logic [79:0] model_vec();
        logic [79:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*10 +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_x[i]   = 80 * i;
            m_div[i] = 0;
        end
    endtask

    task automatic model_frame(input int lvl);
        int eff;
        for (int i = 0; i < 8; i++) begin
            eff = per[i] - lvl;
            if (eff < 1) eff = 1;
            if (m_div[i] >= eff - 1) begin
                m_div[i] = 0;
                if (i % 2 == 1) m_x[i] = (m_x[i] + 2) % 640;
                else            m_x[i] = (m_x[i] + 640 - 2) % 640;
            end else begin
                m_div[i]++;
            end
        end
    endtask

    task automatic push_exp(input string tag, input logic [79:0] hmask, input logic [79:0] hx);
        exp_t e;
        e.tag = tag;
        e.exp_x = model_vec();
        e.hand_mask = hmask;
        e.hand_x = hx;
        sb_q.push_back(e);
    endtask

    task automatic run_frame(input string tag, input logic [79:0] hmask, input logic [79:0] hx);
        if (!pause) begin
            model_frame(int'(level));
            push_exp(tag, hmask, hx);
        end
        @(posedge clk); #2 v_count = 10'd480;
        @(posedge clk); #2 v_count = 10'd481;
        repeat (14) @(posedge clk);
        #2 v_count = 10'd0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Checks lane k becomes visible at T+2+k while later lanes still hold.
    task automatic run_stagger_frame(input string tag);
        logic [79:0] old_x, new_x, exp_x;
        old_x = model_vec();
        model_frame(int'(level));
        new_x = model_vec();
        push_exp(tag, '0, '0);
        @(posedge clk); #2 v_count = 10'd480;
        @(posedge clk); #1;
        check("stagger_tick", 80'(frame_tick), 80'(1));
        check("stagger_busy", 80'(busy), 80'(1));
        check("stagger_hold", car_x, old_x);
        #1 v_count = 10'd481;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            exp_x = old_x;
            for (int j = 0; j <= k; j++) exp_x[j*10 +: 10] = new_x[j*10 +: 10];
            check($sformatf("stagger_lane%0d", k), car_x, exp_x);
        end
        repeat (6) @(posedge clk);
        #2 v_count = 10'd0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cycles++;
            if (update_done) done_cycles++;
            if (frame_tick) begin
                tick_count++;
                tick_cyc = cyc;
                if (!pause) check("busy_at_tick", 80'(busy), 80'(1));
            end
            if (update_done) begin
                check("done_latency", 80'(cyc - tick_cyc), 80'(8));
                check("busy_low_at_done", 80'(busy), 80'(0));
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update_done actual=pulse expected=none at cycle %0d", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_car_x"}, car_x, e.exp_x);
                    if (e.hand_mask != '0) check({e.tag, "_hand"}, car_x & e.hand_mask, e.hand_x);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] snap_x;
        int t0, b0, d0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_car_x", car_x, init_vec());
        check("rst_hold_busy", 80'(busy), 80'(0));
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_car_x", car_x, init_vec());
        check("idle_busy", 80'(busy), 80'(0));
        check("idle_done", 80'(update_done), 80'(0));
        check("idle_tick", 80'(frame_tick), 80'(0));
        #1;
        model_reset();

        // Level 0, frames 1..7
        level = 3'd0;
        for (int f = 1; f <= 7; f++) begin
            if (f == 4)
                run_frame("f4", lane_field(0, 1023) | lane_field(1, 1023) | lane_field(3, 1023),
                          lane_field(0, 638) | lane_field(1, 82) | lane_field(3, 244));
            else if (f == 7)
                run_frame("f7", lane_field(2, 1023), lane_field(2, 158));
            else
                run_frame($sformatf("f%0d", f), '0, '0);
        end

        // Level raise with lane 2 div = 2 moves lane 2 on the next frame
        level = 3'd3;
        run_frame("f8_level3", lane_field(2, 1023), lane_field(2, 156));

        // Level 7: every lane moves every frame; lane 7 right wrap
        level = 3'd7;
        run_stagger_frame("f9_level7");
        for (int f = 10; f <= 45; f++) begin
            if (f == 43)      run_frame("f43", lane_field(7, 1023), lane_field(7, 638));
            else if (f == 44) run_frame("f44_wrap", lane_field(7, 1023), lane_field(7, 0));
            else if (f == 45) run_frame("f45", lane_field(7, 1023), lane_field(7, 2));
            else              run_frame($sformatf("f%0d", f), '0, '0);
        end

        // Pause for 3 frames
        pause = 1'b1;
        #1;
        snap_x = car_x;
        t0 = tick_count;
        b0 = busy_cycles;
        d0 = done_cycles;
        repeat (3) run_frame("paused", '0, '0);
        check("pause_ticks", 80'(tick_count - t0), 80'(3));
        check("pause_busy", 80'(busy_cycles - b0), 80'(0));
        check("pause_done", 80'(done_cycles - d0), 80'(0));
        check("pause_car_x", car_x, snap_x);
        pause = 1'b0;
        level = 3'd0;
        run_frame("unpause1", '0, '0);
        run_frame("unpause2", '0, '0);

        // Reset mid-sweep at T+4
        level = 3'd2;
        @(posedge clk); #2 v_count = 10'd480;
        @(posedge clk); #2 v_count = 10'd481;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_rst", 80'(busy), 80'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_car_x", car_x, init_vec());
        check("rst_mid_busy", 80'(busy), 80'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #2 v_count = 10'd0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        run_frame("post_rst", lane_field(0, 1023) | lane_field(1, 1023),
                  lane_field(0, 0) | lane_field(1, 82));

        repeat (10) @(posedge clk);
        #1;
        check("sb_drained", 80'(sb_q.size()), 80'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
